// File: rtl/mult_bus_pkg.sv
// mult_bus_pkg: shared register map, FSM encoding and bus helpers for the multiplier initiator
package mult_bus_pkg;
  localparam logic [1:0] ADDR_A = 2'd0;
  localparam logic [1:0] ADDR_B = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_RES = 2'd3;
  localparam logic [15:0] INIT = 16'h0001;
  typedef enum logic [3:0] {IDLE, WR_A, WR_B, WR_INIT, POLL, RD_RES, FIN, ERR, GAP} state_t;
  function automatic logic [1:0] addr_of(input state_t s);
    return s == WR_A ? ADDR_A : s == WR_B ? ADDR_B : s == RD_RES ? ADDR_RES : ADDR_CTRL;
  endfunction
  function automatic logic is_xact(input state_t s);
    return s inside {WR_A, WR_B, WR_INIT, POLL, RD_RES};
  endfunction
endpackage

// File: rtl/bus_hold_timer.sv
// bus_hold_timer: loadable down-counter flagging the last cycle of a bus strobe
module bus_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         last
);
  logic [W-1:0] cnt;
  // reload while no transaction is active, otherwise count down to zero and stop
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign last = cnt == '0;
endmodule

// File: rtl/mult_bus_initiator.sv
// mult_bus_initiator: drives a bus-attached multiplier through write, poll and result-read phases
module mult_bus_initiator
  import mult_bus_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int MAX_POLLS = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic        cs,
  output logic [1:0]  addr,
  output logic        rd,
  output logic        wr,
  output logic [15:0] d_out,
  input  logic [15:0] d_in
);
  state_t state, nxt;
  logic [15:0] a_q, b_q;
  logic [7:0] polls;
  logic last, load, timeout;
  assign load = !is_xact(state);
  assign timeout = {1'b0, polls} + 9'd1 == 9'(MAX_POLLS);
  bus_hold_timer #(.W(4)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value(4'(HOLD - 1)),
    .last(last)
  );
  // sequencer: the GAP state launches the next transaction so every bus output is registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      nxt <= IDLE;
      a_q <= '0;
      b_q <= '0;
      polls <= '0;
      result <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cs <= 1'b0;
      rd <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      d_out <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_q <= a_in;
          b_q <= b_in;
          polls <= '0;
          nxt <= WR_A;
          state <= GAP;
          busy <= 1'b1;
        end
        GAP: begin
          state <= nxt;
          cs <= 1'b1;
          rd <= nxt == POLL || nxt == RD_RES;
          wr <= !(nxt == POLL || nxt == RD_RES);
          addr <= addr_of(nxt);
          d_out <= nxt == WR_A ? a_q : nxt == WR_B ? b_q : nxt == WR_INIT ? INIT : '0;
        end
        FIN, ERR: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: if (last) begin
          cs <= 1'b0;
          rd <= 1'b0;
          wr <= 1'b0;
          addr <= '0;
          d_out <= '0;
          state <= GAP;
          case (state)
            WR_A: nxt <= WR_B;
            WR_B: nxt <= WR_INIT;
            WR_INIT: nxt <= POLL;
            POLL: if (d_in[0]) nxt <= RD_RES;
            else begin
              polls <= polls + 8'd1;
              nxt <= POLL;
              state <= timeout ? ERR : GAP;
              err <= timeout;
            end
            default: begin
              result <= d_in;
              state <= FIN;
              done <= 1'b1;
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: doc/mult_bus_initiator.md
MULT_BUS_INITIATOR -- requirements
Module: mult_bus_initiator

Interface
REQ-001 SHALL have parameter HOLD, default 4, meaning cycles each bus strobe is held asserted (legal range 1..15).
REQ-002 SHALL have parameter MAX_POLLS, default 255, meaning status reads before giving up (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request one multiply.
REQ-006 SHALL have port a_in, input, 16 bits: operand A.
REQ-007 SHALL have port b_in, input, 16 bits: operand B.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse on poll timeout.
REQ-011 SHALL have port result, output, 16 bits: last product read from the peripheral.
REQ-012 SHALL have port cs, output, 1 bit: peripheral chip select.
REQ-013 SHALL have port addr, output, 2 bits: peripheral register address.
REQ-014 SHALL have port rd, output, 1 bit: peripheral read strobe.
REQ-015 SHALL have port wr, output, 1 bit: peripheral write strobe.
REQ-016 SHALL have port d_out, output, 16 bits: write data to the peripheral d_in.
REQ-017 SHALL have port d_in, input, 16 bits: read data from the peripheral d_out.

Function
REQ-018 SHALL use the peripheral map: addr 0 write A; addr 1 write B; addr 2 write bit0=1 starts the multiply, read bit0 = done status; addr 3 read the 16-bit product.
REQ-019 SHALL implement the states IDLE, WR_A, WR_B, WR_INIT, POLL, RD_RES, FIN, ERR, with one GAP cycle after each bus transaction.
REQ-020 SHALL drive cs, rd, wr, addr and d_out to 0 in IDLE, GAP, FIN and ERR; all bus outputs SHALL be registered.
REQ-021 SHALL accept start only in IDLE, latching a_in and b_in on that edge and entering WR_A on the next cycle; start while busy SHALL be ignored.
REQ-022 SHALL hold each transaction (cs=1 plus the matching rd/wr, addr and d_out) for exactly HOLD cycles, timed by a counter that resets at each phase entry.
REQ-023 SHALL sequence writes as: WR_A (addr 0, d_out=A), then GAP, then WR_B (addr 1, d_out=B), then GAP, then WR_INIT (addr 2, d_out=16'h0001), then GAP, then POLL.
REQ-024 In POLL, SHALL read addr 2 and sample d_in[0] on the last hold cycle: if 1, go via GAP to RD_RES; if 0, increment the poll count and go via GAP back to POLL.
REQ-025 SHALL enter ERR when the poll count reaches MAX_POLLS with no done seen; ERR SHALL pulse err for 1 cycle, leave result unchanged, then go to IDLE.
REQ-026 In RD_RES, SHALL read addr 3 and capture d_in into result on the last hold cycle, then go to FIN.
REQ-027 FIN SHALL pulse done for 1 cycle and then go to IDLE.
REQ-028 result SHALL hold its value until the next successful RD_RES.
REQ-029 Total latency from start to done, with the status ready at the first poll, SHALL be 1 + 5*HOLD + 5 cycles.
REQ-030 A start seen in the same cycle as done SHALL be ignored; the next start is accepted no earlier than the following IDLE cycle.

Reset
REQ-031 On rst==0 at a clock edge, SHALL enter IDLE and set busy, done, err, cs, rd, wr, addr, d_out, result, the hold counter, the poll count and the latched operands all to 0.
REQ-032 Reset mid-transaction SHALL deassert the bus strobes on the same edge and SHALL produce no done or err pulse.

Structure
REQ-033 SHALL place the address constants (A, B, CTRL, RES), the state encoding and the INIT value 16'h0001 in a shared package mult_bus_pkg.
REQ-034 SHALL contain one sub-module, bus_hold_timer, a loadable down-counter with a last-cycle flag used for the hold timing.

Verification
REQ-035 A=5, B=2, start, with a peripheral model reporting done at the first poll -> write sequence 0/5, 1/2, 2/1 each held 4 cycles with gaps; result=10; done pulse exactly 26 cycles after start.
REQ-036 A=300, B=300 -> result=24464 (low 16 bits of 90000).
REQ-037 Model never reports done, MAX_POLLS=3 -> exactly 3 poll reads, err pulses once, done never pulses, result unchanged.
REQ-038 start pulsed during WR_B -> ignored: operands unchanged and only one done pulse.
REQ-039 rst=0 during POLL -> on the next cycle all outputs are 0 and state is IDLE; a following start completes normally.
REQ-040 Back-to-back starts (the second in the cycle after done) -> the second operation completes with correct result and identical timing.
